// File: rtl/cpu_pkg.sv
// Shared CPU register-file constants and the write-back request type.
package cpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int PC_IDX     = 15;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer of pending ALU write-backs, with a per-entry view
// (logical order, entry 0 = head) used to build the busy mask.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  wb_req_t                             wr_req,
    input  logic                                pop,
    output wb_req_t                             head,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(DEPTH+1)-1:0]          count,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_rd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_req;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        entry_valid = '0;
        entry_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = (CNT_W'(i) < count);
            entry_rd[i]    = mem[rd_ptr + PTR_W'(i)].rd;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port driver: merges load and ALU results into one
// registered write per cycle, forwards same-cycle hits and tracks busy registers.
module regfile_writeback #(
    parameter int DATA_W = cpu_pkg::REG_DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int DEPTH  = 2,
    parameter int PC_IDX = cpu_pkg::PC_IDX
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_rd_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              fwd_a_valid_o,
    output logic [DATA_W-1:0] fwd_a_data_o,
    output logic              fwd_b_valid_o,
    output logic [DATA_W-1:0] fwd_b_data_o,
    output logic              pc_wr_o,
    output logic [15:0]       busy_mask_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    cpu_pkg::wb_req_t alu_req;
    cpu_pkg::wb_req_t head;
    cpu_pkg::wb_req_t sel;
    logic             sel_valid;
    logic             passthrough;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0][cpu_pkg::REG_ADDR_W-1:0] entry_rd;
    logic [15:0]      busy_next;

    assign alu_req.rd   = alu_rd_i;
    assign alu_req.data = alu_data_i;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .push        (push),
        .wr_req      (alu_req),
        .pop         (pop),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    // ALU handshake: a result transfers on a rising edge where alu_valid_i &&
    // alu_ready_o; the producer holds rd/data stable while valid is high and
    // ready is low. Loads carry no handshake and always win the write port,
    // which keeps program order since a load is older than any buffered entry.
    always_comb begin
        sel         = alu_req;
        sel_valid   = 1'b0;
        pop         = 1'b0;
        passthrough = 1'b0;
        if (ld_valid_i) begin
            sel_valid = 1'b1;
            sel.rd    = ld_rd_i;
            sel.data  = ld_data_i;
        end else if (!empty) begin
            sel_valid = 1'b1;
            sel       = head;
            pop       = 1'b1;
        end else if (alu_valid_i) begin
            sel_valid   = 1'b1;
            passthrough = 1'b1;
        end
        alu_ready_o = (count < CNT_W'(DEPTH)) || (full && pop);
        push        = alu_valid_i && alu_ready_o && !passthrough;
    end

    // Mask of the state after this edge: surviving entries, the new push
    // and the write about to appear on the port.
    always_comb begin
        busy_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && !(pop && i == 0)) busy_next[entry_rd[i]] = 1'b1;
        end
        if (push)      busy_next[alu_rd_i] = 1'b1;
        if (sel_valid) busy_next[sel.rd]   = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_o       <= 1'b0;
            wr_addr_o     <= '0;
            wr_data_o     <= '0;
            pc_wr_o       <= 1'b0;
            fwd_a_valid_o <= 1'b0;
            fwd_a_data_o  <= '0;
            fwd_b_valid_o <= 1'b0;
            fwd_b_data_o  <= '0;
            busy_mask_o   <= '0;
        end else begin
            wr_en_o <= sel_valid;
            if (sel_valid) begin
                wr_addr_o <= sel.rd;
                wr_data_o <= sel.data;
            end
            pc_wr_o       <= sel_valid && (sel.rd == ADDR_W'(PC_IDX));
            fwd_a_valid_o <= wr_en_o && (wr_addr_o == a_addr_i);
            if (wr_en_o && (wr_addr_o == a_addr_i)) fwd_a_data_o <= wr_data_o;
            fwd_b_valid_o <= wr_en_o && (wr_addr_o == b_addr_i);
            if (wr_en_o && (wr_addr_o == b_addr_i)) fwd_b_data_o <= wr_data_o;
            busy_mask_o   <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: per-cycle reference of the
// write selection, a write scoreboard, and directed plus random scenarios.
module tb_regfile_writeback;

    localparam int W     = 36;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic [3:0]  a_addr;
    logic [3:0]  b_addr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        fwd_a_valid;
    logic [31:0] fwd_a_data;
    logic        fwd_b_valid;
    logic [31:0] fwd_b_data;
    logic        pc_wr;
    logic [15:0] busy_mask;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] alu_pend[$];
    int checks = 0;
    int fails  = 0;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .alu_valid_i   (alu_valid),
        .alu_rd_i      (alu_rd),
        .alu_data_i    (alu_data),
        .alu_ready_o   (alu_ready),
        .ld_valid_i    (ld_valid),
        .ld_rd_i       (ld_rd),
        .ld_data_i     (ld_data),
        .a_addr_i      (a_addr),
        .b_addr_i      (b_addr),
        .wr_en_o       (wr_en),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .fwd_a_valid_o (fwd_a_valid),
        .fwd_a_data_o  (fwd_a_data),
        .fwd_b_valid_o (fwd_b_valid),
        .fwd_b_data_o  (fwd_b_data),
        .pc_wr_o       (pc_wr),
        .busy_mask_o   (busy_mask)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every write on the port must match the oldest expected one.
    always begin
        logic [W-1:0] e;
        @(posedge clk);
        #2;
        if (rst_n && wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got r%0d=%h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    fails++;
                    $display("FAIL write_data: got r%0d=%h, required r%0d=%h",
                             wr_addr, wr_data, e[35:32], e[31:0]);
                end
                checks++;
                if (pc_wr !== (e[35:32] == 4'd15)) begin
                    fails++;
                    $display("FAIL pc_wr: got %b, required %b", pc_wr, (e[35:32] == 4'd15));
                end
            end
        end else if (rst_n) begin
            checks++;
            if (pc_wr !== 1'b0) begin
                fails++;
                $display("FAIL pc_wr_idle: got %b, required 0", pc_wr);
            end
        end
    end

    // Driver: one cycle of stimulus with a reference of selection/ready/busy.
    // Called at posedge+1, returns at the following posedge+1.
    task automatic drive_cycle(input logic lv, input logic [3:0] lrd, input logic [31:0] ldat,
                               input logic av, input logic [3:0] ard, input logic [31:0] adat,
                               output logic acc);
        logic        exp_ready;
        logic        sel;
        logic        pass;
        logic [3:0]  sel_rd;
        logic [15:0] exp_busy;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldat;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        #3;
        exp_ready = (alu_pend.size() < DEPTH) || (alu_pend.size() == DEPTH && !lv);
        checks++;
        if (alu_ready !== exp_ready) begin
            fails++;
            $display("FAIL alu_ready: got %b, required %b", alu_ready, exp_ready);
        end
        acc    = av && exp_ready;
        sel    = 1'b0;
        pass   = 1'b0;
        sel_rd = '0;
        if (lv) begin
            exp_q.push_back({lrd, ldat});
            sel    = 1'b1;
            sel_rd = lrd;
        end else if (alu_pend.size() != 0) begin
            sel_rd = alu_pend[0][35:32];
            exp_q.push_back(alu_pend.pop_front());
            sel = 1'b1;
        end else if (av) begin
            exp_q.push_back({ard, adat});
            sel    = 1'b1;
            pass   = 1'b1;
            sel_rd = ard;
        end
        if (acc && !pass) alu_pend.push_back({ard, adat});
        exp_busy = '0;
        foreach (alu_pend[i]) exp_busy[alu_pend[i][35:32]] = 1'b1;
        if (sel) exp_busy[sel_rd] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy_mask !== exp_busy) begin
            fails++;
            $display("FAIL busy_mask: got %h, required %h", busy_mask, exp_busy);
        end
    endtask

    task automatic idle_cycle();
        logic acc;
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || alu_pend.size() != 0); i++) idle_cycle();
        checks++;
        if (exp_q.size() != 0 || alu_pend.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d writes outstanding, required 0", exp_q.size() + alu_pend.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({wr_en, wr_addr, wr_data, pc_wr, fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data} !== '0) begin
            fails++;
            $display("FAIL %s_outputs: got wr_en=%b addr=%0d data=%h pc=%b fa=%b/%h fb=%b/%h, required all 0",
                     tag, wr_en, wr_addr, wr_data, pc_wr, fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data);
        end
        checks++;
        if (busy_mask !== 16'h0) begin
            fails++;
            $display("FAIL %s_busy: got %h, required 0000", tag, busy_mask);
        end
        checks++;
        if (alu_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_ready: got %b, required 1", tag, alu_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycle();
        checks++;
        if (wr_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_write: got %b, required 0", wr_en);
        end
    endtask

    task automatic test_passthrough();
        logic acc;
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h0000_00A5, acc);
        checks++;
        if ({wr_en, wr_addr, wr_data, busy_mask} !== {1'b1, 4'd3, 32'h0000_00A5, 16'h0008}) begin
            fails++;
            $display("FAIL passthrough: got en=%b r%0d=%h busy=%h, required en=1 r3=000000a5 busy=0008",
                     wr_en, wr_addr, wr_data, busy_mask);
        end
        idle_cycle();
        checks++;
        if (busy_mask !== 16'h0) begin
            fails++;
            $display("FAIL passthrough_busy_clear: got %h, required 0000", busy_mask);
        end
        drain();
    endtask

    task automatic test_load_priority();
        logic acc;
        drive_cycle(1'b1, 4'd2, 32'h1111, 1'b1, 4'd2, 32'h2222, acc);
        checks++;
        if (acc !== 1'b1 || wr_data !== 32'h1111) begin
            fails++;
            $display("FAIL load_priority: got acc=%b data=%h, required acc=1 data=00001111", acc, wr_data);
        end
        idle_cycle();
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd2, 32'h2222}) begin
            fails++;
            $display("FAIL load_then_alu: got en=%b r%0d=%h, required en=1 r2=00002222", wr_en, wr_addr, wr_data);
        end
        drain();
    endtask

    task automatic test_back_pressure();
        logic        acc;
        logic [31:0] k;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            drive_cycle(c < 4, 4'(c + 8), 32'h1000 + 32'(c), 1'b1, 4'(k[2:0]), 32'h2000 + k, acc);
            if (acc) k++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic acc;
        for (int c = 0; c < 5; c++) drive_cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'(c + 1), 32'hB000 + 32'(c), acc);
        drain();
    endtask

    task automatic test_forwarding();
        logic acc;
        a_addr = 4'd5;
        b_addr = 4'd5;
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hDEAD_BEEF, acc);
        idle_cycle();
        checks++;
        if ({fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL fwd_both: got a=%b/%h b=%b/%h, required a=1/deadbeef b=1/deadbeef",
                     fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data);
        end
        a_addr = 4'd6;
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h1234_5678, acc);
        idle_cycle();
        checks++;
        if ({fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data} !== {1'b0, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678}) begin
            fails++;
            $display("FAIL fwd_miss_a: got a=%b/%h b=%b/%h, required a=0/deadbeef b=1/12345678",
                     fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data);
        end
        a_addr = 4'd0;
        b_addr = 4'd0;
        drain();
    endtask

    task automatic test_pc_write();
        logic acc;
        drive_cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h0000_0100, acc);
        checks++;
        if ({pc_wr, wr_en} !== 2'b11) begin
            fails++;
            $display("FAIL pc_write: got pc_wr=%b wr_en=%b, required 1 1", pc_wr, wr_en);
        end
        idle_cycle();
        checks++;
        if (pc_wr !== 1'b0) begin
            fails++;
            $display("FAIL pc_write_clear: got %b, required 0", pc_wr);
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        logic acc;
        drive_cycle(1'b1, 4'd1, 32'hA0, 1'b1, 4'd9, 32'hC0, acc);
        drive_cycle(1'b1, 4'd4, 32'hA1, 1'b1, 4'd10, 32'hC1, acc);
        checks++;
        if (busy_mask !== 16'h0610) begin
            fails++;
            $display("FAIL mid_op_busy: got %h, required 0610", busy_mask);
        end
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        alu_pend.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idle_cycle();
            checks++;
            if (wr_en !== 1'b0) begin
                fails++;
                $display("FAIL write_after_reset: got wr_en=%b r%0d, required 0", wr_en, wr_addr);
            end
        end
    endtask

    task automatic test_random();
        logic        lv, av, acc, pending;
        logic [3:0]  lrd, ard;
        logic [31:0] ldat, adat;
        pending = 1'b0;
        av      = 1'b0;
        ard     = '0;
        adat    = '0;
        for (int c = 0; c < 80; c++) begin
            if (!pending) begin
                av   = ($urandom_range(0, 2) != 0);
                ard  = 4'($urandom_range(0, 15));
                adat = $urandom();
            end
            lv   = ($urandom_range(0, 2) == 0);
            lrd  = 4'($urandom_range(0, 15));
            ldat = $urandom();
            drive_cycle(lv, lrd, ldat, av, ard, adat, acc);
            pending = av && !acc;
        end
        drain();
    endtask

    initial begin
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
        a_addr    = '0;
        b_addr    = '0;
        test_reset();
        test_passthrough();
        test_load_priority();
        test_back_pressure();
        test_back_to_back();
        test_forwarding();
        test_pc_write();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side driver for the CPU's 16x32 register file (registered read ports, one synchronous write port).
- Accepts ALU results through a valid/ready handshake and load results unconditionally, and issues at most one register write per cycle.
- Produces forwarding data for the read ports. The register file returns the pre-write value when a read and a write hit the same register in the same cycle; the forwarding outputs cover that case.
- Publishes a pending-write mask for issue-stage hazard checks.

Parameters:
- DATA_W, 32: register data width.
- ADDR_W, 4: register index width (16 registers).
- DEPTH, 2: ALU result buffer entries (power of two, >=2).
- PC_IDX, 15: register index treated as the program counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- alu_valid_i  in  1  ALU result present
- alu_rd_i  in  ADDR_W  ALU destination register
- alu_data_i  in  DATA_W  ALU result
- alu_ready_o  out  1  buffer can accept an ALU result this cycle
- ld_valid_i  in  1  load result present; always accepted, no back-pressure
- ld_rd_i  in  ADDR_W  load destination register
- ld_data_i  in  DATA_W  load data
- a_addr_i  in  ADDR_W  register file port A read address this cycle
- b_addr_i  in  ADDR_W  register file port B read address this cycle
- wr_en_o  out  1  register file write enable
- wr_addr_o  out  ADDR_W  register file write address
- wr_data_o  out  DATA_W  register file write data
- fwd_a_valid_o  out  1  replace register file port A output this cycle
- fwd_a_data_o  out  DATA_W  forwarded value for port A
- fwd_b_valid_o  out  1  replace register file port B output this cycle
- fwd_b_data_o  out  DATA_W  forwarded value for port B
- pc_wr_o  out  1  pulses together with a write to PC_IDX
- busy_mask_o  out  16  bit r set while a write to r is buffered or on the write port

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - Buffer empty.
  - wr_en_o, wr_addr_o, wr_data_o, pc_wr_o, fwd_*_valid_o, fwd_*_data_o = 0.
  - busy_mask_o = 0.
  - alu_ready_o = 1, since it is decoded from buffer count and the buffer is empty.
- Reset mid-operation discards all buffered and in-flight writes. No write is issued on the cycle reset deasserts.
- ALU handshake:
  - An ALU result is accepted when alu_valid_i & alu_ready_o.
  - alu_ready_o = (count < DEPTH), or when count==DEPTH and a buffered entry is selected for writing this cycle.
  - Data is captured on the rising edge of acceptance.
- Write selection, evaluated each cycle in priority order:
  1. ld_valid_i.
  2. Head of the ALU buffer.
  3. The ALU input in the same cycle it arrives (passthrough) when the buffer is empty and no load is present.
- Ordering: the issue stage guarantees that a load arriving on ld_* is older than every buffered ALU entry. Issuing loads first therefore preserves program order for same-rd (WAW) cases.
- Latency: the selected write appears on wr_en_o/wr_addr_o/wr_data_o one cycle after selection; all three are registered outputs.
  - Passthrough ALU path: accepted at cycle N, wr_en_o=1 at N+1.
  - Load path: ld_valid_i at N, wr_en_o=1 at N+1.
- Buffer occupancy on a load collision:
  - An ALU entry and a load arriving together: the ALU entry enters the buffer if ready, and the load writes.
  - Buffer full with a load present: alu_ready_o=0 that cycle.
- pc_wr_o is registered, equal to (selected write) & (rd==PC_IDX), and aligned with wr_en_o.
- Forwarding:
  - At each edge where wr_en_o=1 and wr_addr_o==a_addr_i, register fwd_a_valid_o=1 and fwd_a_data_o=wr_data_o; otherwise fwd_a_valid_o=0 and fwd_a_data_o holds its value.
  - The result aligns with the register file's port A output, one cycle later.
  - Port B works identically using b_addr_i.
  - Both ports may forward in the same cycle.
- busy_mask_o is registered. It is the OR of one-hot(rd) over valid buffer entries and one-hot(wr_addr_o) when wr_en_o=1, updated each edge.
- Buffer wrap-around: read and write pointers are ADDR-free modulo DEPTH, with count tracked separately. Simultaneous push and pop at full or empty keeps the count unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ADDR_W=4, REG_DATA_W=32, PC_IDX=15.
  - Typedef wb_req_t {rd, data}.
- One sub-module, wb_fifo: a DEPTH-entry wb_req_t FIFO with push, pop, full, empty, count, and an entry-valid/rd view for the busy mask.

Test Plan:
- ALU passthrough: alu_valid_i=1, rd=3, data=0x0000_00A5 at cycle 0 with empty buffer -> cycle 1 wr_en_o=1, wr_addr_o=3, wr_data_o=0xA5; busy_mask_o bit 3 set in cycle 1 only.
- Load priority: ld_valid_i (rd=2, 0x1111) and alu_valid_i (rd=2, 0x2222) in the same cycle -> writes 0x1111 then 0x2222 to r2 on consecutive cycles, alu_ready_o stays 1.
- Back-pressure: loads every cycle for 4 cycles plus ALU valid every cycle -> buffer fills, alu_ready_o=0 from cycle 2, no ALU result lost, all writes in order once loads stop.
- Forwarding: write r5=0xDEAD_BEEF on the write port while a_addr_i=5 and b_addr_i=5 -> next cycle fwd_a_valid_o=fwd_b_valid_o=1, data 0xDEADBEEF; with a_addr_i=6, fwd_a_valid_o=0.
- PC write: ALU rd=15, data=0x100 -> pc_wr_o=1 in the same cycle as wr_en_o, otherwise 0.
- Reset mid-operation: buffer holds 2 entries, assert rst_ni=0 asynchronously -> outputs 0 immediately, busy_mask_o=0, no writes after release, alu_ready_o=1.
